// File: rtl/c_frame_demux_1_2_pkg.sv
// Shared types for the complex frame demultiplexer: sample payload, frame
// length default and the ping-pong routing state.
package c_frame_demux_1_2_pkg;

  localparam int unsigned FFT_DATA_WIDTH = 16;
  localparam int unsigned FFT_FRAME_LEN  = 16;

  // Complex sample as carried between FFT stages
  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] r;
    logic signed [FFT_DATA_WIDTH-1:0] i;
  } cplx_t;

  // Which output lane currently receives input frames
  typedef enum logic {
    S_P0 = 1'b0,
    S_P1 = 1'b1
  } demux_state_e;

endpackage

// File: rtl/c_frame_demux_1_2_out_slot.sv
// c_out_slot: one registered valid/ready output slot holding a complex sample
// and its end-of-frame flag.
//   load_i      : write data_i/last_i into the slot this cycle
//   ready_i     : downstream consumer ready
//   free_c_o    : slot can take a sample this cycle (empty or draining)
//   valid_o/data_o/last_o : registered slot contents
module c_out_slot #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          free_c_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          last_q;

  assign free_c_o = !valid_q || ready_i;

  // Reload wins over drain so back-to-back transfers keep valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/c_frame_demux_1_2.sv
// c_frame_demux_1_2: steers whole frames of complex samples alternately to
// out0 and out1 (ping-pong) from a single valid/ready input stream.
//   in_*       : input stream (valid/ready, signed real/imag)
//   out0_*     : lane 0 slot (valid/ready, real/imag, last = final sample of frame)
//   out1_*     : lane 1 slot, same as out0
//   frm_cnt0/1 : completed frames consumed per lane, only with C_DEMUX_FRMCNT_EN
module c_frame_demux_1_2
  import c_frame_demux_1_2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int unsigned FRAME_LEN  = FFT_FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_r,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  output logic                         out0_valid,
  input  logic                         out0_ready,
  output logic signed [DATA_WIDTH-1:0] out0_r,
  output logic signed [DATA_WIDTH-1:0] out0_i,
  output logic                         out0_last,
  output logic                         out1_valid,
  input  logic                         out1_ready,
  output logic signed [DATA_WIDTH-1:0] out1_r,
  output logic signed [DATA_WIDTH-1:0] out1_i,
  output logic                         out1_last
`ifdef C_DEMUX_FRMCNT_EN
  ,
  output logic [7:0]                   frm_cnt0,
  output logic [7:0]                   frm_cnt1
`endif
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned PW    = 2 * DATA_WIDTH;

  demux_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_en_q;
  logic             free0, free1, accept, last_in;
  logic             load0, load1;
  logic [PW-1:0]    slot0_data, slot1_data;

  // Input ready is held low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign in_ready = rdy_en_q && ((state_q == S_P0) ? free0 : free1);
  assign accept   = in_valid && in_ready;
  assign last_in  = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign load0    = accept && (state_q == S_P0);
  assign load1    = accept && (state_q == S_P1);

  // State and sample-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_P0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Advance count per accept; swap lanes on the final sample of a frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
      if (last_in) begin
        state_d = (state_q == S_P0) ? S_P1 : S_P0;
      end
    end
  end

  c_out_slot #(.DW(PW)) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load0),
    .data_i   ({in_r, in_i}),
    .last_i   (last_in),
    .ready_i  (out0_ready),
    .free_c_o (free0),
    .valid_o  (out0_valid),
    .data_o   (slot0_data),
    .last_o   (out0_last)
  );

  c_out_slot #(.DW(PW)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load1),
    .data_i   ({in_r, in_i}),
    .last_i   (last_in),
    .ready_i  (out1_ready),
    .free_c_o (free1),
    .valid_o  (out1_valid),
    .data_o   (slot1_data),
    .last_o   (out1_last)
  );

  assign out0_r = slot0_data[PW-1:DATA_WIDTH];
  assign out0_i = slot0_data[DATA_WIDTH-1:0];
  assign out1_r = slot1_data[PW-1:DATA_WIDTH];
  assign out1_i = slot1_data[DATA_WIDTH-1:0];

`ifdef C_DEMUX_FRMCNT_EN
  logic [7:0] frm_cnt0_q, frm_cnt1_q;

  // Count frames whose last sample has been consumed; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt0_q <= '0;
      frm_cnt1_q <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last) frm_cnt0_q <= 8'(frm_cnt0_q + 1'b1);
      if (out1_valid && out1_ready && out1_last) frm_cnt1_q <= 8'(frm_cnt1_q + 1'b1);
    end
  end

  assign frm_cnt0 = frm_cnt0_q;
  assign frm_cnt1 = frm_cnt1_q;
`endif

endmodule

// File: tb/tb_c_frame_demux_1_2.sv
// Directed bench for c_frame_demux_1_2: reset, ping-pong streaming,
// per-lane backpressure, frame boundary with held last, mid-frame reset,
// and (with C_DEMUX_FRMCNT_EN) frame counters.
module tb_c_frame_demux_1_2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_r, in_i;
  logic        out0_valid, out0_ready, out0_last;
  logic [15:0] out0_r, out0_i;
  logic        out1_valid, out1_ready, out1_last;
  logic [15:0] out1_r, out1_i;
`ifdef C_DEMUX_FRMCNT_EN
  logic [7:0]  frm_cnt0, frm_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  c_frame_demux_1_2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_i       (in_i),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_r     (out0_r),
    .out0_i     (out0_i),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_r     (out1_r),
    .out1_i     (out1_i),
    .out1_last  (out1_last)
`ifdef C_DEMUX_FRMCNT_EN
    ,
    .frm_cnt0   (frm_cnt0),
    .frm_cnt1   (frm_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic drive(input bit v, input int k, input bit r0, input bit r1);
    in_valid   = v;
    in_r       = 16'(k);
    in_i       = 16'(-k);
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expect lane `lane` to hold sample k with given last flag
  task automatic chk_slot(input string tag, input int lane, input int k, input bit last);
    logic [15:0] er, ei;
    er = 16'(k);
    ei = 16'(-k);
    if (lane == 0) begin
      chk({tag, ".v0"}, out0_valid, 1);
      chk({tag, ".r0"}, out0_r, er);
      chk({tag, ".i0"}, out0_i, ei);
      chk({tag, ".l0"}, out0_last, last);
    end else begin
      chk({tag, ".v1"}, out1_valid, 1);
      chk({tag, ".r1"}, out1_r, er);
      chk({tag, ".i1"}, out1_i, ei);
      chk({tag, ".l1"}, out1_last, last);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 1, 1);
    #2;
    // 1: reset state
    chk("rst.in_ready", in_ready, 0);
    chk("rst.v0", out0_valid, 0);
    chk("rst.v1", out1_valid, 0);
    chk("rst.l0", out0_last, 0);
    chk("rst.l1", out1_last, 0);
    chk("rst.r0", out0_r, 0);
    chk("rst.i1", out1_i, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel.in_ready", in_ready, 1);

    // 2: two full frames, both lanes ready, one sample per cycle
    for (int k = 0; k < 32; k++) begin
      drive(1, k, 1, 1);
      #1;
      chk("strm.in_ready", in_ready, 1);
      tick();
      if (k < 16) begin
        chk_slot("strm", 0, k, k == 15);
        chk("strm.v1idle", out1_valid, 0);
      end else begin
        chk_slot("strm", 1, k, k == 31);
        chk("strm.v0idle", out0_valid, 0);
      end
    end
    drive(0, 0, 1, 1);
    tick();
    chk("idle.v0", out0_valid, 0);
    chk("idle.v1", out1_valid, 0);

    // 3: backpressure on lane 0 with sample 3 held
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 1, 1);
      tick();
    end
    chk_slot("bp.s3", 0, 3, 0);
    drive(1, 4, 0, 1);
    #1;
    chk("bp.in_ready_lo", in_ready, 0);
    tick();
    tick();
    chk_slot("bp.hold", 0, 3, 0);
    chk("bp.in_ready_hold", in_ready, 0);
    out0_ready = 1'b1;
    #1;
    chk("bp.in_ready_rel", in_ready, 1);
    tick();
    chk_slot("bp.s4", 0, 4, 0);
    for (int k = 5; k < 16; k++) begin
      drive(1, k, 1, 1);
      tick();
      chk_slot("bp.run", 0, k, k == 15);
    end

    // 4: lane 0 stalls on its last; lane 1 keeps streaming
    for (int k = 16; k < 20; k++) begin
      drive(1, k, 0, 1);
      #1;
      chk("fb.in_ready", in_ready, 1);
      tick();
      chk_slot("fb.l1", 1, k, 0);
      chk_slot("fb.l0held", 0, 15, 1);
    end
    drive(0, 0, 1, 1);
    tick();
    chk("fb.v0drained", out0_valid, 0);

    // 5: reset mid-frame (lane 1 index 7 about to arrive)
    for (int k = 20; k < 23; k++) begin
      drive(1, k, 1, 1);
      tick();
    end
    drive(1, 23, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.in_ready", in_ready, 0);
    chk("mrst.v1", out1_valid, 0);
    chk("mrst.r1", out1_r, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 100; k < 116; k++) begin
      drive(1, k, 1, 1);
      tick();
      chk_slot("mrst.f", 0, k, k == 115);
      chk("mrst.v1idle", out1_valid, 0);
    end
    drive(1, 116, 1, 1);
    tick();
    chk_slot("mrst.next", 1, 116, 0);

`ifdef C_DEMUX_FRMCNT_EN
    // 6: frame counters over four frames, then wrap after 512 frames
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      drive(1, k, 1, 1);
      tick();
    end
    drive(0, 0, 1, 1);
    tick();
    chk("fc.cnt0", frm_cnt0, 2);
    chk("fc.cnt1", frm_cnt1, 2);
    for (int k = 0; k < 508 * 16; k++) begin
      drive(1, k, 1, 1);
      tick();
    end
    drive(0, 0, 1, 1);
    tick();
    chk("fc.wrap0", frm_cnt0, 0);
    chk("fc.wrap1", frm_cnt1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
